// File: rtl/tinycpu_pkg.sv
// Shared tinycpu constants: instruction width, opcodes and default address width.
// Pure declarations; no timing or flow-control behaviour of its own.
package tinycpu_pkg;

  localparam int INSTR_W        = 16;
  localparam int DEFAULT_ADDR_W = 8;

  localparam logic [3:0] OP_LI  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry queue of fetched {instr, pc}; head is registered, visible the cycle after its push.
// A push into a full queue without a simultaneous pop is dropped; flush empties it and beats push.
module fetch_buf
  import tinycpu_pkg::*;
#(
  parameter int W = INSTR_W + DEFAULT_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         push_ok;
  logic         pop_ok;

  assign empty    = (count == 2'd0);
  assign full     = (count == 2'd2);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign head_dat = slot0;

  // slot0 is always the head; a pop shifts slot1 forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_dat;
          else               slot1 <= push_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_dat;
          end else begin
            slot0 <= slot1;
            slot1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle imem, 2-entry buffer; first instr 2 cycles after its request, jump target 3 cycles after redirect.
// Requests stop while buffer + in-flight would exceed 2 entries; define FETCH_HALT_EN for a halt input that blocks new requests.
module fetch_unit
  import tinycpu_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FETCH_HALT_EN
  input  logic               halt,
`endif
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  fetch_entry_t      head_dat;
  fetch_entry_t      push_dat;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_vld;
  logic [1:0]        buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic              pop;
  logic              redirect;
  logic              push;
  logic              halted;
  logic [2:0]        occupancy;

`ifdef FETCH_HALT_EN
  assign halted = halt;
`else
  assign halted = 1'b0;
`endif

  assign instr_valid = !buf_empty;
  assign instr       = head_dat.instr;
  assign instr_pc    = head_dat.pc;
  assign pop         = instr_valid && instr_ready;

  // Only a pop can redirect, and the flush leaves nothing to pop until the
  // target word arrives, so a second redirect cannot precede the target.
  assign redirect = pop && jump_en;

  always_comb begin
    occupancy = {1'b0, buf_count} + {2'b00, inflight_vld} - {2'b00, pop};
    imem_req  = !rst && !redirect && !halted && (occupancy < 3'd2);
  end

  assign imem_addr = pc_q;

  // The response landing in a redirect cycle belongs to the abandoned path.
  assign push     = inflight_vld && !redirect && (!buf_full || pop);
  assign push_dat = '{instr: imem_rdata, pc: inflight_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      inflight_vld <= 1'b0;
      inflight_pc  <= '0;
    end else begin
      inflight_vld <= imem_req;
      if (imem_req) inflight_pc <= pc_q;
      if (redirect)      pc_q <= jump_target;
      else if (imem_req) pc_q <= pc_q + ADDR_W'(1);
    end
  end

  fetch_buf #(
    .W($bits(fetch_entry_t))
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head_dat),
    .count    (buf_count),
    .full     (buf_full),
    .empty    (buf_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized stream checked against an in-order program model.
module tb_fetch_unit;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata = 16'hDEAD;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          jump_en = 1'b0;
  logic [AW-1:0] jump_target = '0;
`ifdef FETCH_HALT_EN
  logic          halt = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] mem [256];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FETCH_HALT_EN
    .halt        (halt),
`endif
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_target (jump_target)
  );

  // Synchronous memory: data for a request appears during the following cycle.
  initial begin
    logic          pv;
    logic [AW-1:0] pa;
    forever begin
      @(negedge clk);
      pv = imem_req;
      pa = imem_addr;
      @(posedge clk);
      #1 imem_rdata = pv ? mem[pa] : 16'hDEAD;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    instr_ready = 1'b0;
    jump_en     = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b, want 0", imem_req); else n_pass++;
    n_total++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %0b, want 0", instr_valid); else n_pass++;
    n_total++;
    if (instr !== 16'h0000) $display("FAIL reset_instr: got %h, want 0000", instr); else n_pass++;
    n_total++;
    if (instr_pc !== 8'h00) $display("FAIL reset_pc: got %h, want 00", instr_pc); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00})
      $display("FAIL release_req: got req=%0b addr=%h, want req=1 addr=00", imem_req, imem_addr);
    else n_pass++;
    n_total++;
    if (instr_valid !== 1'b0) $display("FAIL release_valid: got %0b, want 0", instr_valid); else n_pass++;
  endtask

  // Linear stream with a 5-cycle stall while pc=3 is at the head.
  task automatic test_linear_stall();
    logic [7:0] e;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      instr_ready = !(c >= 5 && c <= 9);
      @(negedge clk);
      n_total++;
      if (c < 2) begin
        if (instr_valid !== 1'b0) $display("FAIL linear_idle c=%0d: got valid=%0b, want 0", c, instr_valid);
        else n_pass++;
      end else begin
        e = (c <= 4) ? 8'(c - 2) : (c <= 10) ? 8'd3 : 8'(c - 7);
        if ({instr_valid, instr_pc, instr} !== {1'b1, e, mem[e]})
          $display("FAIL linear c=%0d: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                   c, instr_valid, instr_pc, instr, e, mem[e]);
        else n_pass++;
      end
      if (c >= 6 && c <= 9) begin
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL stall_req c=%0d: got %0b, want 0", c, imem_req); else n_pass++;
      end
    end
    instr_ready = 1'b0;
  endtask

  // Redirect to 0x40 on the pop of pc=5.
  task automatic test_jump();
    logic [7:0] e;
    do_reset();
    jump_target = 8'h40;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      instr_ready = 1'b1;
      jump_en     = (c == 7);
      @(negedge clk);
      n_total++;
      if (c < 2 || c == 8 || c == 9) begin
        if (instr_valid !== 1'b0) $display("FAIL jump_bubble c=%0d: got valid=%0b, want 0", c, instr_valid);
        else n_pass++;
      end else begin
        e = (c <= 7) ? 8'(c - 2) : 8'(8'h40 + c - 10);
        if ({instr_valid, instr_pc, instr} !== {1'b1, e, mem[e]})
          $display("FAIL jump c=%0d: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                   c, instr_valid, instr_pc, instr, e, mem[e]);
        else n_pass++;
      end
      if (c == 7) begin
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL jump_req_redirect: got %0b, want 0", imem_req); else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h40})
          $display("FAIL jump_req_target: got req=%0b addr=%h, want req=1 addr=40", imem_req, imem_addr);
        else n_pass++;
      end
    end
    instr_ready = 1'b0;
    jump_en     = 1'b0;
  endtask

  // jump_en without a pop (idle, then stalled head) must not redirect.
  task automatic test_jump_ignored();
    logic [7:0] e;
    do_reset();
    jump_target = 8'h40;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      instr_ready = (c != 5);
      jump_en     = (c == 1 || c == 5);
      @(negedge clk);
      if (c >= 2) begin
        e = (c <= 5) ? 8'(c - 2) : 8'(c - 3);
        n_total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, e, mem[e]})
          $display("FAIL jump_ignored c=%0d: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                   c, instr_valid, instr_pc, instr, e, mem[e]);
        else n_pass++;
      end
    end
    instr_ready = 1'b0;
    jump_en     = 1'b0;
  endtask

  // Jump near the top of the address space and let the PC wrap.
  task automatic test_wrap();
    logic [7:0] e;
    do_reset();
    jump_target = 8'hFE;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      instr_ready = 1'b1;
      jump_en     = (c == 3);
      @(negedge clk);
      if (c >= 6) begin
        e = 8'hFE + 8'(c - 6);
        n_total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, e, mem[e]})
          $display("FAIL wrap c=%0d: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                   c, instr_valid, instr_pc, instr, e, mem[e]);
        else n_pass++;
      end
    end
    instr_ready = 1'b0;
    jump_en     = 1'b0;
  endtask

  // One-cycle reset while the buffer holds a word and a response is in flight.
  task automatic test_mid_reset();
    logic [7:0] e;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      rst         = (c == 5);
      instr_ready = (c != 5);
      @(negedge clk);
      if (c == 5) begin
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL midrst_req: got %0b, want 0", imem_req); else n_pass++;
      end else if (c == 6 || c == 7) begin
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL midrst_valid c=%0d: got %0b, want 0", c, instr_valid);
        else n_pass++;
        if (c == 6) begin
          n_total++;
          if ({imem_req, imem_addr} !== {1'b1, 8'h00})
            $display("FAIL midrst_restart: got req=%0b addr=%h, want req=1 addr=00", imem_req, imem_addr);
          else n_pass++;
        end
      end else if (c >= 8) begin
        e = 8'(c - 8);
        n_total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, e, mem[e]})
          $display("FAIL midrst c=%0d: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                   c, instr_valid, instr_pc, instr, e, mem[e]);
        else n_pass++;
      end
    end
    instr_ready = 1'b0;
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    logic [7:0] e;
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      instr_ready = 1'b1;
      halt        = (c >= 5 && c <= 12);
      @(negedge clk);
      if (c >= 5 && c <= 12) begin
        n_total++;
        if (imem_req !== 1'b0) $display("FAIL halt_req c=%0d: got %0b, want 0", c, imem_req); else n_pass++;
      end
      if (c >= 7 && c <= 14) begin
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL halt_drain c=%0d: got %0b, want 0", c, instr_valid);
        else n_pass++;
      end else if (c >= 2) begin
        e = (c <= 6) ? 8'(c - 2) : 8'(c - 10);
        n_total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, e, mem[e]})
          $display("FAIL halt c=%0d: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                   c, instr_valid, instr_pc, instr, e, mem[e]);
        else n_pass++;
      end
    end
    halt        = 1'b0;
    instr_ready = 1'b0;
  endtask
`endif

  // Random ready/jump traffic against an in-order program model.
  task automatic test_random();
    logic [7:0]  exp_pc;
    logic [7:0]  prev_pc;
    logic [15:0] prev_instr;
    logic        prev_hold;
    int          age;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    exp_pc = 8'h00; prev_pc = 8'h00; prev_instr = 16'h0000; prev_hold = 1'b0; age = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      instr_ready = ($urandom_range(0, 9) < 7);
      jump_en     = ($urandom_range(0, 7) == 0);
      jump_target = 8'($urandom);
      @(negedge clk);
      if (age >= 0) age++;
      if (prev_hold) begin
        n_total++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, prev_pc, prev_instr})
          $display("FAIL rnd_hold c=%0d: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                   c, instr_valid, instr_pc, instr, prev_pc, prev_instr);
        else n_pass++;
      end
      if (age == 1 || age == 2) begin
        n_total++;
        if (instr_valid !== 1'b0) $display("FAIL rnd_bubble c=%0d: got valid=%0b, want 0", c, instr_valid);
        else n_pass++;
      end else if (age == 3) begin
        n_total++;
        if (instr_valid !== 1'b1) $display("FAIL rnd_target c=%0d: got valid=%0b, want 1", c, instr_valid);
        else n_pass++;
      end
      if (age >= 3) age = -1;
      if (instr_valid === 1'b1 && instr_ready) begin
        n_total++;
        if ({instr_pc, instr} !== {exp_pc, mem[exp_pc]})
          $display("FAIL rnd_stream c=%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                   c, instr_pc, instr, exp_pc, mem[exp_pc]);
        else n_pass++;
        if (jump_en) begin
          exp_pc = jump_target;
          age    = 0;
        end else begin
          exp_pc = exp_pc + 8'd1;
        end
      end
      prev_hold  = (instr_valid === 1'b1) && !instr_ready;
      prev_pc    = instr_pc;
      prev_instr = instr;
    end
    instr_ready = 1'b0;
    jump_en     = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset();
    test_linear_stall();
    test_jump();
    test_jump_ignored();
    test_wrap();
    test_mid_reset();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
